alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus an optional iterative multiply/divide unit.
// Define ALU_MC_MDU_EN to build the MUL/MULHU/DIV/DIVU/REM/REMU datapath (ops 10-15).
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             accept;
  logic [SHW-1:0]   shamt;

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign data_o  = data_q;
  assign zero_o  = zero_q;
  // Flush wins over a simultaneous request, which is then dropped.
  assign accept  = valid_i && ready_o && !flush_i;
  assign shamt   = data2_i[SHW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    case (ALUCtrl_i)
      4'd0: alu_res = data1_i + data2_i;
      4'd1: alu_res = data1_i - data2_i;
      4'd2: alu_res = data1_i & data2_i;
      4'd3: alu_res = data1_i | data2_i;
      4'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      4'd5: begin
        alu_res  = data1_i ^ data2_i;
        alu_zero = (data1_i == data2_i);
      end
      4'd6: alu_res = data1_i << shamt;
      4'd7: alu_res = data1_i >> shamt;
      4'd8: alu_res = $signed(data1_i) >>> shamt;
      4'd9: alu_zero = (data1_i != data2_i);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MC_MDU_EN
  // acc_q high half: partial product / remainder; low half: multiplier / dividend->quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         op_q, op_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic               is_mdu_op, sgn_div;
  logic [WIDTH-1:0]   a_mag, b_mag, mdu_res;

  assign is_mdu_op = ALUCtrl_i[3] & (ALUCtrl_i[2] | ALUCtrl_i[1]);
  assign sgn_div   = ~ALUCtrl_i[0];
  assign a_mag     = (sgn_div && data1_i[WIDTH-1]) ? -data1_i : data1_i;
  assign b_mag     = (sgn_div && data2_i[WIDTH-1]) ? -data2_i : data2_i;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign acc_step  = op_q[2]
                   ? {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
                   : {mul_sum, acc_q[WIDTH-1:1]};

  // Result is formed from the final step so DONE follows the last iteration directly.
  always_comb begin
    case (op_q)
      3'b010:  mdu_res = acc_step[WIDTH-1:0];
      3'b011:  mdu_res = acc_step[2*WIDTH-1:WIDTH];
      3'b100:  mdu_res = qneg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      3'b101:  mdu_res = acc_step[WIDTH-1:0];
      3'b110:  mdu_res = rneg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      3'b111:  mdu_res = acc_step[2*WIDTH-1:WIDTH];
      default: mdu_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
`ifdef ALU_MC_MDU_EN
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_MC_MDU_EN
          if (is_mdu_op) begin
            state_d = S_BUSY;
            op_d    = ALUCtrl_i[2:0];
            cnt_d   = '0;
            if (ALUCtrl_i[2]) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
              // A zero divisor keeps the all-ones quotient unsigned.
              qneg_d = sgn_div && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]) && (data2_i != '0);
              rneg_d = sgn_div && data1_i[WIDTH-1];
            end else begin
              acc_d  = {{WIDTH{1'b0}}, data2_i};
              opnd_d = data1_i;
              qneg_d = 1'b0;
              rneg_d = 1'b0;
            end
          end else
`endif
          begin
            state_d = S_DONE;
            data_d  = alu_res;
            zero_d  = alu_zero;
          end
        end
      end
      S_BUSY: begin
`ifdef ALU_MC_MDU_EN
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d = S_DONE;
            data_d  = mdu_res;
            zero_d  = 1'b0;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

endmodule
